// File: rtl/doublet_math_pkg.sv
`default_nettype none
// ============================================================================
// Module : doublet_math_pkg
// Desc   : Shared widths and FSM encoding for the doublet math unit.
// Rev    : 1.0
// ============================================================================
package doublet_math_pkg;

  localparam int unsigned OP_WIDTH  = 16;
  localparam int unsigned CNT_WIDTH = 5;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage
`default_nettype wire

// File: rtl/add16.sv
`default_nettype none
// ============================================================================
// Module : add16
// Desc   : 16-bit unsigned adder with carry out.
// Rev    : 1.0
// ============================================================================
module add16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] sum,
  output logic        carry
);

  assign {carry, sum} = {1'b0, a} + {1'b0, b};

endmodule
`default_nettype wire

// File: rtl/mul16.sv
`default_nettype none
// ============================================================================
// Module : mul16
// Desc   : Sequential 16x16 unsigned shift-and-add multiplier built on add16.
//          MUL16_EARLY_EXIT_EN: finish as soon as the remaining multiplier
//          bits are all zero.
// Rev    : 1.0
// ============================================================================
module mul16
  import doublet_math_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [OP_WIDTH-1:0]   in1,
  input  logic [OP_WIDTH-1:0]   in2,
  output logic                  busy,
  output logic                  done,
  output logic [2*OP_WIDTH-1:0] product
);

  state_t                state_q;
  logic [OP_WIDTH-1:0]   a_q;
  logic [2*OP_WIDTH-1:0] p_q;
  logic [2*OP_WIDTH-1:0] p_d;
  logic [CNT_WIDTH-1:0]  cnt_q;
  logic                  busy_q;
  logic                  done_q;
  logic [2*OP_WIDTH-1:0] product_q;

  logic [OP_WIDTH-1:0]   add_sum;
  logic                  add_carry;
  logic [OP_WIDTH:0]     hi17;
  logic                  last_step;

  add16 u_add16 (
    .a     (p_q[2*OP_WIDTH-1:OP_WIDTH]),
    .b     (a_q),
    .sum   (add_sum),
    .carry (add_carry)
  );

  // Carry lands in P[31] after the shift, so nothing is lost.
  always_comb begin
    hi17 = p_q[0] ? {add_carry, add_sum} : {1'b0, p_q[2*OP_WIDTH-1:OP_WIDTH]};
    p_d  = {hi17, p_q[OP_WIDTH-1:1]};
  end

  assign last_step = (cnt_q == CNT_WIDTH'(OP_WIDTH - 1));

`ifdef MUL16_EARLY_EXIT_EN
  logic                  early_done;
  logic [2*OP_WIDTH-1:0] early_prod;

  // The low (16 - count) bits of P are the multiplier bits not yet consumed.
  assign early_done = ((p_q[OP_WIDTH-1:0] & ({OP_WIDTH{1'b1}} >> cnt_q)) == '0);
  assign early_prod = p_q >> (CNT_WIDTH'(OP_WIDTH) - cnt_q);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      a_q       <= '0;
      p_q       <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      product_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q     <= in1;
            p_q     <= {{OP_WIDTH{1'b0}}, in2};
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
`ifdef MUL16_EARLY_EXIT_EN
          if (early_done) begin
            product_q <= early_prod;
            done_q    <= 1'b1;
            busy_q    <= 1'b0;
            state_q   <= IDLE;
          end else
`endif
          begin
            p_q   <= p_d;
            cnt_q <= cnt_q + 1'b1;
            if (last_step) begin
              product_q <= p_d;
              done_q    <= 1'b1;
              busy_q    <= 1'b0;
              state_q   <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;

endmodule
`default_nettype wire

// File: tb/tb_mul16.sv
`default_nettype none
// ============================================================================
// Module : tb_mul16
// Desc   : Directed self-checking bench for mul16 (both build variants).
// Rev    : 1.0
// ============================================================================
module tb_mul16;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] in1;
  logic [15:0] in2;
  logic        busy;
  logic        done;
  logic [31:0] product;

  int n_checks = 0;
  int n_pass   = 0;

  mul16 dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .in1     (in1),
    .in2     (in2),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%08h), expected %0d (0x%08h)", tag, obs, obs, exp, exp);
  endtask

  function automatic int pick_lat(input int lat_fixed, input int lat_early);
`ifdef MUL16_EARLY_EXIT_EN
    return lat_early;
`else
    return lat_fixed;
`endif
  endfunction

  task automatic start_op(input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    in1   = a;
    in2   = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk_eq("busy_after_start", {31'd0, busy}, 32'd1);
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!done && lat < 40);
    chk_eq("done_seen", {31'd0, done}, 32'd1);
  endtask

  task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic [31:0] exp,
                       input int lat_fixed, input int lat_early);
    int lat;
    start_op(a, b);
    wait_done(lat);
    chk_eq("product", product, exp);
    chk_eq("latency", lat, pick_lat(lat_fixed, lat_early));
    chk_eq("busy_at_done", {31'd0, busy}, 32'd0);
    @(posedge clk);
    #1;
    chk_eq("done_one_cycle", {31'd0, done}, 32'd0);
    chk_eq("product_held", product, exp);
  endtask

  initial begin
    int lat;
    int n_done;
    rst   = 1'b1;
    start = 1'b0;
    in1   = '0;
    in2   = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_eq("rst_busy", {31'd0, busy}, 32'd0);
    chk_eq("rst_done", {31'd0, done}, 32'd0);
    chk_eq("rst_product", product, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    do_op(16'd5,    16'd65,   32'd325,        16, 8);
    do_op(16'd255,  16'd100,  32'd25500,      16, 8);
    do_op(16'hFFFF, 16'hFFFF, 32'hFFFE0001,   16, 16);
    do_op(16'd1234, 16'd0,    32'd0,          16, 1);

    // Mid-run start is ignored; start held through done launches the next op.
    start_op(16'd3, 16'd7);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
      if (lat == 1) begin
        start = 1'b1;
        in1   = 16'd9;
        in2   = 16'd9;
      end
    end while (!done && lat < 40);
    chk_eq("done_seen", {31'd0, done}, 32'd1);
    chk_eq("product_ignore_start", product, 32'd21);
    chk_eq("latency_ignore_start", lat, pick_lat(16, 4));
    in1 = 16'd2;
    in2 = 16'd2;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk_eq("b2b_busy", {31'd0, busy}, 32'd1);
    chk_eq("b2b_done_low", {31'd0, done}, 32'd0);
    chk_eq("b2b_product_held", product, 32'd21);
    wait_done(lat);
    chk_eq("b2b_product", product, 32'd4);
    chk_eq("b2b_latency", lat, pick_lat(16, 3));

    // Reset in the middle of a run aborts it silently.
    start_op(16'd100, 16'd100);
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk_eq("abort_busy", {31'd0, busy}, 32'd0);
    chk_eq("abort_done", {31'd0, done}, 32'd0);
    chk_eq("abort_product", product, 32'd0);
    @(negedge clk);
    rst    = 1'b0;
    n_done = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (done) n_done++;
    end
    chk_eq("abort_no_done", n_done, 32'd0);
    chk_eq("abort_product_after", product, 32'd0);

    do_op(16'd100, 16'd100, 32'd10000, 16, 8);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
